// File: rtl/noc_merge2.sv
// noc_merge2: two-input flit merge stage with a small FIFO per input and a
// round-robin arbiter feeding one registered output port.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   in0_data/valid/ready     input channel 0 (valid/ready)
//   in1_data/valid/ready     input channel 1 (valid/ready)
//   out_data/valid/ready     merged output channel, out_data/out_valid registered
//   out_src                  source index of out_data (only with MERGE_SRC_TAG_EN)
//
// Build option: define MERGE_SRC_TAG_EN to add the out_src port and register.
module noc_merge2 #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
`ifdef MERGE_SRC_TAG_EN
    output logic         out_src,
`endif
    input  logic         out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [W-1:0]  mem   [2][DEPTH];
    logic [AW-1:0] wptr  [2];
    logic [AW-1:0] rptr  [2];
    logic [CW-1:0] cnt   [2];
    logic          last;

    logic [1:0]    in_valid;
    logic [W-1:0]  in_data [2];
    logic [1:0]    not_empty;
    logic [1:0]    can_push;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          load;
    logic          any_req;
    logic          grant;
    logic [W-1:0]  head;

    assign in_valid   = {in1_valid, in0_valid};
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            not_empty[i] = (cnt[i] != '0);
            // Ready comes from registered occupancy only, so a full FIFO being
            // popped this cycle still refuses the incoming flit.
            can_push[i]  = (cnt[i] != Full);
            push[i]      = in_valid[i] && can_push[i];
        end
    end

    assign in0_ready = can_push[0];
    assign in1_ready = can_push[1];

    assign load    = !out_valid || out_ready;
    assign any_req = |not_empty;

    // Single requester wins outright; on a tie the input not granted last wins.
    always_comb begin
        if (&not_empty) begin
            grant = !last;
        end else begin
            grant = not_empty[1];
        end
    end

    always_comb begin
        pop = 2'b00;
        if (load && any_req) begin
            pop[grant] = 1'b1;
        end
    end

    assign head = grant ? mem[1][rptr[1]] : mem[0][rptr[0]];

    // Storage has no reset; stale entries are never read because cnt gates pops.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wptr[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wptr[i] <= wptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rptr[i] <= rptr[i] + AW'(1);
                end
                if (push[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            last      <= 1'b1;
        end else if (load) begin
            out_valid <= any_req;
            if (any_req) begin
                out_data <= head;
                last     <= grant;
            end
        end
    end

`ifdef MERGE_SRC_TAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_src <= 1'b0;
        end else if (load && any_req) begin
            out_src <= grant;
        end
    end
`endif

endmodule

// File: tb/tb_noc_merge2.sv
module tb_noc_merge2;

    localparam int W     = 9;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in0_data = '0;
    logic         in0_valid = 1'b0;
    logic         in0_ready;
    logic [W-1:0] in1_data = '0;
    logic         in1_valid = 1'b0;
    logic         in1_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
`ifdef MERGE_SRC_TAG_EN
    logic         out_src;
`endif

    always #5 clk = ~clk;

    noc_merge2 #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef MERGE_SRC_TAG_EN
        .out_src   (out_src),
`endif
        .out_ready (out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-input queues of accepted flits plus the output slot.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           m_ov;
    logic [W-1:0] m_od;
    bit           m_src;
    bit           m_last;

    // Producer scripts and the log of flits the DUT handed downstream.
    logic [W-1:0] src0[$];
    logic [W-1:0] src1[$];
    logic [W-1:0] dut_log[$];
    bit           acc0, acc1;
    int           vprob = 100;
    int           rmode = 1;
    bit           rand_fill = 0;
    int           cyc;
    int           first_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_ov   = 0;
        m_od   = '0;
        m_src  = 0;
        m_last = 1;
        acc0   = 0;
        acc1   = 0;
    endtask

    // One clock edge of the reference behaviour, from pre-edge state.
    task automatic model_edge();
        bit r0, r1, g;
        r0   = (q0.size() != DEPTH);
        r1   = (q1.size() != DEPTH);
        acc0 = in0_valid && r0;
        acc1 = in1_valid && r1;
        if (!m_ov || out_ready) begin
            if (q0.size() > 0 || q1.size() > 0) begin
                if (q0.size() == 0)      g = 1;
                else if (q1.size() == 0) g = 0;
                else                     g = !m_last;
                m_od   = g ? q1.pop_front() : q0.pop_front();
                m_ov   = 1;
                m_src  = g;
                m_last = g;
            end else begin
                m_ov = 0;
            end
        end
        if (acc0) q0.push_back(in0_data);
        if (acc1) q1.push_back(in1_data);
    endtask

    task automatic check_outputs();
        check_eq("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check_eq("out_data", out_data, m_od);
`ifdef MERGE_SRC_TAG_EN
            check_eq("out_src", out_src, m_src);
`endif
        end
        check_eq("in0_ready", in0_ready, q0.size() != DEPTH);
        check_eq("in1_ready", in1_ready, q1.size() != DEPTH);
        if (out_valid && first_v < 0) first_v = cyc;
    endtask

    task automatic gen_inputs();
        if (rand_fill) begin
            if (src0.size() < 2) src0.push_back(W'($urandom));
            if (src1.size() < 2) src1.push_back(W'($urandom));
        end
        if (acc0 || !in0_valid) begin
            if (src0.size() > 0 && $urandom_range(99) < vprob) begin
                in0_data  = src0.pop_front();
                in0_valid = 1;
            end else begin
                in0_valid = 0;
            end
        end
        if (acc1 || !in1_valid) begin
            if (src1.size() > 0 && $urandom_range(99) < vprob) begin
                in1_data  = src1.pop_front();
                in1_valid = 1;
            end else begin
                in1_valid = 0;
            end
        end
        case (rmode)
            0:       out_ready = 0;
            1:       out_ready = 1;
            default: out_ready = ($urandom_range(99) < 60);
        endcase
        if (out_valid && out_ready) dut_log.push_back(out_data);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            cyc++;
            check_outputs();
            gen_inputs();
        end
    endtask

    task automatic drain(input int max);
        int k = 0;
        while ((src0.size() > 0 || src1.size() > 0 || q0.size() > 0 || q1.size() > 0 ||
                m_ov || in0_valid || in1_valid) && k < max) begin
            run(1);
            k++;
        end
        check_eq("drain_done", k < max, 1);
    endtask

    // Called just after a falling edge; asserts reset mid-cycle.
    task automatic do_reset();
        #2 reset_n = 0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_in0_ready", in0_ready, 1);
        check_eq("rst_in1_ready", in1_ready, 1);
`ifdef MERGE_SRC_TAG_EN
        check_eq("rst_out_src", out_src, 0);
`endif
        model_reset();
        src0.delete();
        src1.delete();
        dut_log.delete();
        in0_valid = 0;
        in1_valid = 0;
        rand_fill = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        cyc     = 0;
        first_v = -1;
    endtask

    initial begin
        logic [W-1:0] exp_single [3];
        logic [W-1:0] exp_tie [4];
        exp_single = '{9'h1A3, 9'h0F1, 9'h155};
        exp_tie    = '{9'h101, 9'h1F1, 9'h102, 9'h1F2};
        model_reset();
        @(negedge clk);
        do_reset();

        // Single input, back-to-back.
        src0  = '{9'h1A3, 9'h0F1, 9'h155};
        vprob = 100;
        rmode = 1;
        gen_inputs();
        drain(100);
        check_eq("single_latency", first_v, 2);
        check_eq("single_count", dut_log.size(), 3);
        for (int i = 0; i < 3 && i < dut_log.size(); i++)
            check_eq("single_order", dut_log[i], exp_single[i]);

        // Tie from reset: input 0 wins first, then alternation.
        do_reset();
        src0 = '{9'h101, 9'h102};
        src1 = '{9'h1F1, 9'h1F2};
        gen_inputs();
        drain(100);
        check_eq("tie_count", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++)
            check_eq("tie_order", dut_log[i], exp_tie[i]);

        // Backpressure: both FIFOs fill and readies drop, then drain.
        do_reset();
        rmode = 0;
        src0  = '{9'h011, 9'h012, 9'h013};
        src1  = '{9'h021, 9'h022, 9'h023};
        gen_inputs();
        run(6);
        check_eq("bp_in0_ready_low", in0_ready, 0);
        check_eq("bp_in1_ready_low", in1_ready, 0);
        check_eq("bp_no_output", dut_log.size(), 0);
        rmode = 1;
        drain(100);
        check_eq("bp_total", dut_log.size(), 6);

        // Reset mid-stream with flits buffered; nothing stale may appear.
        do_reset();
        rmode = 0;
        src0  = '{9'h0A1, 9'h0A2, 9'h0A3};
        gen_inputs();
        run(4);
        do_reset();
        rmode = 1;
        gen_inputs();
        run(6);
        check_eq("rst_no_stale", dut_log.size(), 0);

        // Wrap-around: 20 incrementing flits through input 1, random out_ready.
        do_reset();
        vprob = 70;
        rmode = 2;
        for (int i = 0; i < 20; i++) src1.push_back(W'(9'h060 + i));
        gen_inputs();
        drain(1000);
        check_eq("wrap_count", dut_log.size(), 20);
        for (int i = 0; i < 20 && i < dut_log.size(); i++)
            check_eq("wrap_order", dut_log[i], W'(9'h060 + i));

        // Random traffic on both inputs.
        do_reset();
        vprob     = 60;
        rmode     = 2;
        rand_fill = 1;
        gen_inputs();
        run(500);
        rand_fill = 0;
        drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
